aes_128_pipeline: RTL and testbench
===================================

Name: aes_128_pipeline

Overview:
AES-128 encryption engine (FIPS-197). It accepts one 128-bit plaintext and one 128-bit key per request and computes the round keys inline, round by round. It raises valid_out/done with the ciphertext. It sits behind a simple start/valid request port and serves as the block-cipher primitive for higher-level crypto wrappers.

Parameters:
PIPELINED, 1, 1 = registered output stage after round 10 (+1 cycle latency); 0 = outputs driven directly from the round-10 register.
UNROLL, 1, rounds computed per clock; legal values 1, 2, 5, 10; any other value is a synthesis-time error.
INLINE_KEY_EXP, 1, 1 = round key n derived from round key n-1 in the same cycle as round n; only value 1 is supported; 0 is a synthesis-time error.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  request strobe; qualified with valid_in.
mode  input  1  0 = encrypt; 1 = reserved (decrypt not implemented).
data_in  input  128  plaintext, byte 0 = bits [127:120].
key_in  input  128  cipher key, same byte order.
valid_in  input  1  input data valid.
data_out  output  128  ciphertext, same byte order.
valid_out  output  1  one-cycle pulse, ciphertext valid.
done  output  1  one-cycle pulse, coincident with valid_out.

Behaviour:
- Reset (rst low, asynchronous): state idle; data_out = 0, valid_out = 0, done = 0; round counter = 0. All internal registers clear.
- Accept: at a rising edge with idle & start & valid_in & mode==0:
  - state <= data_in ^ key_in; round key <= key_in; counter <= 0; go busy.
- mode==1 requests are ignored: the block stays idle and raises neither done nor valid_out.
- start/valid_in while busy are ignored. There is no queueing, and inputs need only be valid on the accept edge.
- Busy: each edge applies UNROLL rounds, each round being:
  - SubBytes, ShiftRows, MixColumns (MixColumns omitted in round 10), then AddRoundKey.
  - Round key n is the standard expansion with Rcon 01,02,04,08,10,20,40,80,1b,36.
- Latency from the accept edge to the edge where done/valid_out go high is 10/UNROLL + PIPELINED cycles. With the defaults this is 11 cycles.
- Completion:
  - data_out is loaded with the ciphertext; done = valid_out = 1 for exactly one cycle; block returns to idle.
  - data_out holds its value until the next completion or reset.
- A new request may be accepted on the edge after done drops, so back-to-back requests are spaced latency+1 cycles apart.
- Reset asserted mid-operation aborts the computation immediately; no done follows.

Decomposition:
- Package aes_pkg holds:
  - the S-box constant (256x8);
  - the Rcon constant array;
  - functions xtime, sub_word, rot_word, shift_rows and mix_columns;
  - the AES_ROUNDS=10 constant.
- Sub-module aes_round: combinational, with inputs state, round key and a last flag; outputs next state and next round key. It is instantiated UNROLL times in a chain.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a; done one cycle, 11 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e; 8 back-to-back random vectors, each started after the previous done, all match a software model, and done never stays high more than 1 cycle.
- start pulsed again at cycle 5 of a busy operation with different data -> ignored; the first ciphertext is output unchanged and only one done pulse occurs.
- rst driven low at cycle 6 of an operation -> data_out=0 and done/valid_out stay 0. A fresh request after release produces the correct result.
- mode=1 with start&valid_in -> no done within 20 cycles; a subsequent mode=0 request completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte-level helpers.
// State and word byte order: byte 0 = bits [127:120], column-major.
package aes_pkg;
  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIN} state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i < 4'd10) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_round.sv
// One combinational AES round with the matching key-schedule step folded in.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic [7:0]   rcon_i,
  input  logic         last_i,
  output logic [127:0] state_o,
  output logic [127:0] rkey_o
);
  logic [127:0] sb, sr, mc;
  logic [31:0]  t, k0, k1, k2, k3;

  always_comb begin
    sb = '0;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = SBOX[state_i[8*i +: 8]];
  end

  assign sr = shift_rows(sb);
  assign mc = last_i ? sr : mix_columns(sr);

  assign t  = sub_word(rot_word(rkey_i[31:0])) ^ {rcon_i, 24'h0};
  assign k0 = rkey_i[127:96] ^ t;
  assign k1 = rkey_i[95:64]  ^ k0;
  assign k2 = rkey_i[63:32]  ^ k1;
  assign k3 = rkey_i[31:0]   ^ k2;

  assign rkey_o  = {k0, k1, k2, k3};
  assign state_o = mc ^ rkey_o;
endmodule

// File: rtl/aes_128_pipeline.sv
// AES-128 encrypt engine: UNROLL rounds per clock, inline key expansion,
// optional registered output stage after the final round.
module aes_128_pipeline
  import aes_pkg::*;
#(
  parameter int PIPELINED      = 1,
  parameter int UNROLL         = 1,
  parameter int INLINE_KEY_EXP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  input  logic         valid_in,
  output logic [127:0] data_out,
  output logic         valid_out,
  output logic         done
);
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_128_pipeline: UNROLL must be 1, 2, 5 or 10");
  end
  if (INLINE_KEY_EXP != 1) begin : g_bad_kexp
    $error("aes_128_pipeline: only INLINE_KEY_EXP=1 is supported");
  end

  state_e       state_q;
  logic [127:0] st_q, rk_q, out_q;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q;

  logic [127:0] st_c [UNROLL+1];
  logic [127:0] rk_c [UNROLL+1];

  assign st_c[0] = st_q;
  assign rk_c[0] = rk_q;
  assign cnt_d   = cnt_q + 4'(UNROLL);

  // cnt_q counts rounds already applied, so stage g performs round cnt_q+g+1.
  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    localparam logic [3:0] OFF = 4'(g);
    logic [3:0] rnd;
    assign rnd = cnt_q + OFF;
    aes_round u_round (
      .state_i (st_c[g]),
      .rkey_i  (rk_c[g]),
      .rcon_i  (rcon(rnd)),
      .last_i  (rnd == 4'(AES_ROUNDS-1)),
      .state_o (st_c[g+1]),
      .rkey_o  (rk_c[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start && valid_in && !mode) begin
          st_q    <= data_in ^ key_in;
          rk_q    <= key_in;
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          st_q  <= st_c[UNROLL];
          rk_q  <= rk_c[UNROLL];
          cnt_q <= cnt_d;
          if (cnt_d == 4'(AES_ROUNDS)) begin
            if (PIPELINED != 0) begin
              state_q <= S_FIN;
            end else begin
              out_q   <= st_c[UNROLL];
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_FIN: begin
          out_q   <= st_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out  = out_q;
  assign valid_out = done_q;
  assign done      = done_q;
endmodule

// File: tb/tb_aes_128_pipeline.sv
// Directed + random bench for aes_128_pipeline against a byte-array AES model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_128_pipeline;
  logic         clk = 1'b0;
  logic         rst, start, mode, valid_in, valid_out, done;
  logic [127:0] data_in, key_in, data_out;
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   sbox_m [256];

  always #5 clk = ~clk;

  aes_128_pipeline dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .data_in(data_in), .key_in(key_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .done(done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[j+4*c] = t[j+4*((c+j)%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03) ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Cycles from the accept edge to done, bounded at 40.
  task automatic wait_done(inout int n);
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_req(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp, input string tag);
    int n;
    n = 0;
    data_in = pt; key_in = key; mode = 1'b0; start = 1'b1; valid_in = 1'b1;
    tick();
    start = 1'b0; valid_in = 1'b0; data_in = rnd128(); key_in = rnd128();
    wait_done(n);
    chk({tag, "_latency"}, 128'(n), 128'd11);
    chk({tag, "_data"}, data_out, exp);
    chk({tag, "_valid"}, {127'b0, valid_out}, 128'd1);
    tick();
    chk({tag, "_pulse"}, {126'b0, done, valid_out}, 128'd0);
    chk({tag, "_hold"}, data_out, exp);
  endtask

  initial begin
    logic [127:0] pt, key, exp;
    int n, d;
    rst = 1'b0; start = 1'b0; mode = 1'b0; valid_in = 1'b0;
    data_in = '0; key_in = '0;
    build_sbox();
    #12;
    chk("reset_data", data_out, 128'd0);
    chk("reset_done_valid", {126'b0, done, valid_out}, 128'd0);
    tick();
    rst = 1'b1;
    tick();

    do_req(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_c1");
    do_req(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
           128'h3925841d02dc09fbdc118597196a0b32, "fips_b");
    do_req(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "zeros");
    for (int i = 0; i < 8; i++) begin
      pt = rnd128(); key = rnd128();
      do_req(pt, key, ref_enc(pt, key), $sformatf("rand%0d", i));
    end

    // Second start while busy must be ignored.
    pt = rnd128(); key = rnd128(); exp = ref_enc(pt, key);
    data_in = pt; key_in = key; mode = 1'b0; start = 1'b1; valid_in = 1'b1;
    tick();
    start = 1'b0; valid_in = 1'b0;
    n = 0;
    repeat (4) begin tick(); n++; end
    data_in = rnd128(); key_in = rnd128(); start = 1'b1; valid_in = 1'b1;
    tick(); n++;
    start = 1'b0; valid_in = 1'b0;
    wait_done(n);
    chk("busy_latency", 128'(n), 128'd11);
    chk("busy_data", data_out, exp);
    d = 0;
    repeat (15) begin tick(); d += int'(done); end
    chk("busy_single_done", 128'(d), 128'd0);
    chk("busy_data_hold", data_out, exp);

    // Reset mid-operation aborts and clears the output.
    pt = rnd128(); key = rnd128();
    data_in = pt; key_in = key; start = 1'b1; valid_in = 1'b1;
    tick();
    start = 1'b0; valid_in = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    chk("abort_data", data_out, 128'd0);
    chk("abort_done_valid", {126'b0, done, valid_out}, 128'd0);
    tick(); tick();
    rst = 1'b1;
    d = 0;
    repeat (15) begin tick(); d += int'(done) + int'(valid_out); end
    chk("abort_no_done", 128'(d), 128'd0);
    chk("abort_data_stays0", data_out, 128'd0);
    pt = rnd128(); key = rnd128();
    do_req(pt, key, ref_enc(pt, key), "after_abort");

    // mode=1 requests are dropped.
    exp = data_out;
    data_in = rnd128(); key_in = rnd128(); mode = 1'b1; start = 1'b1; valid_in = 1'b1;
    tick();
    start = 1'b0; valid_in = 1'b0;
    d = 0;
    repeat (20) begin tick(); d += int'(done) + int'(valid_out); end
    chk("mode1_no_done", 128'(d), 128'd0);
    chk("mode1_data_hold", data_out, exp);
    pt = rnd128(); key = rnd128();
    do_req(pt, key, ref_enc(pt, key), "after_mode1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
